// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the architectural PC and walks each instruction
// through fetch, decode hand-off, jump-stage strobe, resolve and commit.
// The PC is a word address, so sequential flow advances it by one.
module pc_fetch_sequencer #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     MAX_COUNT = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            halt_req,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dec_valid,
  output logic [31:0]     dec_instr,
  input  logic            dec_ready,
  input  logic [3:0]      dec_path_index,
  output logic            jmp_en,
  output logic            jmp_jump,
  output logic [PC_W-1:0] jmp_pc,
  output logic [25:0]     jmp_addr,
  output logic [3:0]      jmp_path_index,
  input  logic [PC_W-1:0] jmp_pc_out,
  input  logic            jmp_done,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [31:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_STROBE,
    S_RESOLVE,
    S_COMMIT,
    S_HALT
  } state_t;

  state_t          state;
  state_t          state_n;
  logic            is_jump_path;
  logic [PC_W-1:0] pc_plus_one;

  // The jump stage indexes memory and sees the PC directly, so these are plain
  // views of registered state and stay stable from STROBE through COMMIT.
  assign imem_addr    = pc;
  assign jmp_pc       = pc;
  assign jmp_addr     = dec_instr[25:0];
  assign pc_plus_one  = pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign is_jump_path = (dec_path_index == 4'd5) || (dec_path_index == 4'd6) ||
                        (dec_path_index == 4'd8);

  // Next-state logic: one step per clock; halt is only honoured at the
  // instruction boundaries (IDLE and COMMIT) so no fetch is ever abandoned.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (halt_req)  state_n = S_HALT;
        else if (run)  state_n = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack)  state_n = S_DECODE;
      end
      S_DECODE: begin
        if (dec_ready) state_n = S_STROBE;
      end
      S_STROBE: begin
        state_n = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (jmp_done)  state_n = S_COMMIT;
      end
      S_COMMIT: begin
        if (halt_req)  state_n = S_HALT;
        else if (!run) state_n = S_IDLE;
        else           state_n = S_FETCH;
      end
      S_HALT: begin
        state_n = S_HALT;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State register plus handshake outputs, registered off the next state so
  // they line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      imem_req  <= 1'b0;
      dec_valid <= 1'b0;
      jmp_en    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_n;
      imem_req  <= (state_n == S_FETCH);
      dec_valid <= (state_n == S_DECODE);
      jmp_en    <= (state_n == S_STROBE);
      halted    <= (state_n == S_HALT);
    end
  end

  // Datapath: capture the instruction and its decode, then commit the PC and
  // bump the saturating retire counter once per completed instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      dec_instr      <= 32'd0;
      jmp_path_index <= 4'd0;
      jmp_jump       <= 1'b0;
      retired        <= 32'd0;
    end else begin
      if ((state == S_FETCH) && imem_ack) begin
        dec_instr <= imem_rdata;
      end
      if ((state == S_DECODE) && dec_ready) begin
        jmp_path_index <= dec_path_index;
        jmp_jump       <= is_jump_path;
      end
      if (state == S_COMMIT) begin
        pc <= jmp_jump ? jmp_pc_out : pc_plus_one;
        if (retired != MAX_COUNT) begin
          retired <= retired + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: plays memory, decoder and jump stage around two
// sequencer instances (default, and one starting at all-ones PC with a small
// retire limit) and compares them with an instruction-level model.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] MAX2 = 32'd3;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        halt_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_ready;
  logic [3:0]  dec_path_index;
  logic [31:0] jmp_pc_out;
  logic        jmp_done;

  logic        imem_req, dec_valid, jmp_en, jmp_jump, halted;
  logic [31:0] imem_addr, dec_instr, jmp_pc, pc, retired;
  logic [25:0] jmp_addr;
  logic [3:0]  jmp_path_index;

  logic        imem_req_b, dec_valid_b, jmp_en_b, jmp_jump_b, halted_b;
  logic [31:0] imem_addr_b, dec_instr_b, jmp_pc_b, pc_b, retired_b;
  logic [25:0] jmp_addr_b;
  logic [3:0]  jmp_path_index_b;

  int tests;
  int failed;
  int cyc;
  int jmp_en_cnt;

  logic [31:0] model_pc, model_ret, model_pc_b, model_ret_b;

  pc_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .dec_valid(dec_valid), .dec_instr(dec_instr),
    .dec_ready(dec_ready), .dec_path_index(dec_path_index), .jmp_en(jmp_en),
    .jmp_jump(jmp_jump), .jmp_pc(jmp_pc), .jmp_addr(jmp_addr),
    .jmp_path_index(jmp_path_index), .jmp_pc_out(jmp_pc_out),
    .jmp_done(jmp_done), .pc(pc), .halted(halted), .retired(retired)
  );

  pc_fetch_sequencer #(
    .PC_W(32), .RESET_PC(32'hFFFF_FFFF), .MAX_COUNT(MAX2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .dec_valid(dec_valid_b), .dec_instr(dec_instr_b),
    .dec_ready(dec_ready), .dec_path_index(dec_path_index), .jmp_en(jmp_en_b),
    .jmp_jump(jmp_jump_b), .jmp_pc(jmp_pc_b), .jmp_addr(jmp_addr_b),
    .jmp_path_index(jmp_path_index_b), .jmp_pc_out(jmp_pc_out),
    .jmp_done(jmp_done), .pc(pc_b), .halted(halted_b), .retired(retired_b)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter and jmp_en pulse counter, sampled on the active edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (jmp_en === 1'b1) jmp_en_cnt = jmp_en_cnt + 1;
  end

  // Safety net so the run can never hang.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; imem_ack = 1'b0;
    imem_rdata = 32'd0; dec_ready = 1'b0; dec_path_index = 4'd0;
    jmp_pc_out = 32'd0; jmp_done = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    model_pc = 32'd0; model_ret = 32'd0;
    model_pc_b = 32'hFFFF_FFFF; model_ret_b = 32'd0;
    checkOutput("rst_pc", pc, model_pc);
    checkOutput("rst_retired", retired, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_imem_req", imem_req, 0);
    checkOutput("rst_dec_instr", dec_instr, 0);
    checkOutput("rst_jmp_path", jmp_path_index, 0);
    checkOutput("rst_jmp_jump", jmp_jump, 0);
    checkOutput("rst_pc_b", pc_b, model_pc_b);
  endtask

  task automatic waitFetch(output bit ok);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("fetch_start", imem_req, 1);
    ok = (imem_req === 1'b1);
  endtask

  // One whole instruction: fetch with iw stall cycles, decode with dw stall
  // cycles, resolve held for rw cycles if the jump stage is not yet done.
  task automatic applyStimulus(input logic [31:0] instr, input logic [3:0] path,
                               input logic [31:0] pco, input int iw, input int dw,
                               input int rw, input bit hlt, input bit drop_run);
    bit          ok;
    bit          jump;
    int          c0;
    int          en0;
    int          rw_eff;
    jump = (path == 4'd5) || (path == 4'd6) || (path == 4'd8);
    waitFetch(ok);
    if (!ok) return;
    c0  = cyc;
    en0 = jmp_en_cnt;
    rw_eff = jmp_done ? 0 : rw;
    checkOutput("imem_addr", imem_addr, model_pc);
    for (int i = 0; i < iw; i++) begin
      dec_ready = 1'($urandom_range(0, 1));
      dec_path_index = 4'($urandom);
      @(posedge clk); #1;
      checkOutput("imem_req_hold", imem_req, 1);
      checkOutput("dec_valid_early", dec_valid, 0);
    end
    dec_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = instr;
    @(posedge clk); #1;
    imem_ack = 1'b0; imem_rdata = $urandom;
    checkOutput("imem_req_drop", imem_req, 0);
    checkOutput("dec_valid", dec_valid, 1);
    checkOutput("dec_instr", dec_instr, instr);
    if (hlt) halt_req = 1'b1;
    if (drop_run) run = 1'b0;
    for (int i = 0; i < dw; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(posedge clk); #1;
      checkOutput("dec_valid_hold", dec_valid, 1);
      checkOutput("dec_instr_stable", dec_instr, instr);
    end
    imem_ack = 1'b0;
    dec_ready = 1'b1; dec_path_index = path;
    @(posedge clk); #1;
    dec_ready = 1'b0; dec_path_index = 4'($urandom);
    checkOutput("jmp_en_strobe", jmp_en, 1);
    checkOutput("dec_valid_drop", dec_valid, 0);
    checkOutput("jmp_jump", jmp_jump, jump);
    checkOutput("jmp_path_index", jmp_path_index, path);
    checkOutput("jmp_addr", jmp_addr, instr[25:0]);
    checkOutput("jmp_pc", jmp_pc, model_pc);
    jmp_pc_out = jump ? pco : $urandom;
    @(posedge clk); #1;
    checkOutput("jmp_en_single", jmp_en, 0);
    for (int i = 0; i < rw_eff; i++) begin
      @(posedge clk); #1;
      checkOutput("resolve_wait_pc", pc, model_pc);
    end
    jmp_done = 1'b1;
    @(posedge clk); #1;
    checkOutput("commit_jmp_addr", jmp_addr, instr[25:0]);
    checkOutput("commit_pc_not_yet", pc, model_pc);
    @(posedge clk); #1;
    model_pc    = jump ? pco : model_pc + 32'd1;
    model_pc_b  = jump ? pco : model_pc_b + 32'd1;
    model_ret   = (model_ret == 32'hFFFF_FFFF) ? model_ret : model_ret + 32'd1;
    model_ret_b = (model_ret_b == MAX2) ? model_ret_b : model_ret_b + 32'd1;
    checkOutput("pc", pc, model_pc);
    checkOutput("retired", retired, model_ret);
    checkOutput("pc_b", pc_b, model_pc_b);
    checkOutput("retired_b", retired_b, model_ret_b);
    checkOutput("instr_cycles", 64'(cyc - c0), 64'(5 + iw + dw + rw_eff));
    checkOutput("jmp_en_count", 64'(jmp_en_cnt - en0), 1);
    if (hlt) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput("halted", halted, 1);
        checkOutput("halt_no_req", imem_req, 0);
        @(posedge clk); #1;
      end
    end else begin
      checkOutput("not_halted", halted, 0);
      if (drop_run) begin
        for (int i = 0; i < 3; i++) begin
          checkOutput("idle_after_run_drop", imem_req, 0);
          @(posedge clk); #1;
        end
      end
    end
  endtask

  // Directed and randomized instruction stream.
  initial begin
    bit ok;
    tests = 0; failed = 0; cyc = 0; jmp_en_cnt = 0;
    rst_n = 1'b0;
    resetDut();

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("idle_no_req", imem_req, 0);
    end

    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h0000_1000 + 32'(i), 4'd0, 32'hDEAD_0000, 0, 0, 0, 1'b0, 1'b0);
    end
    applyStimulus(32'h0800_0040, 4'd5, 32'h0000_0040, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus($urandom, 4'd0, 32'h0, 4, 3, 0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      logic [3:0] p;
      p = ($urandom_range(0, 1) == 1) ? ((i % 3 == 0) ? 4'd5 : (i % 3 == 1) ? 4'd6 : 4'd8)
                                      : 4'($urandom);
      applyStimulus($urandom, p, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    0, 1'b0, 1'b0);
    end

    applyStimulus($urandom, 4'd1, 32'h0, 1, 1, 0, 1'b0, 1'b1);
    run = 1'b1;
    applyStimulus($urandom, 4'd8, 32'h1234_5678, 0, 2, 0, 1'b0, 1'b0);
    applyStimulus($urandom, 4'd2, 32'h0, 1, 2, 0, 1'b1, 1'b0);

    resetDut();
    halt_req = 1'b1;
    @(posedge clk); #1;
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("idle_halt", halted, 1);
      checkOutput("idle_halt_no_req", imem_req, 0);
      @(posedge clk); #1;
    end

    resetDut();
    run = 1'b1;
    applyStimulus($urandom, 4'd0, 32'h0, 0, 0, 2, 1'b0, 1'b0);
    waitFetch(ok);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_req", imem_req, 0);
    checkOutput("async_rst_pc", pc, 0);
    checkOutput("async_rst_retired", retired, 0);
    resetDut();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
